// File: rtl/seq_array_multiplier.sv
// Iterative WA x WB multiplier: one partial product per clock, LSB of b first,
// signed or unsigned per operation, start/busy/done handshake.
module seq_array_multiplier #(
    parameter int  WA = 7,
    parameter int  WB = 6,
    localparam int CW = $clog2(WB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              t,
    input  logic [WA-1:0]     a,
    input  logic [WB-1:0]     b,
    output logic [WA+WB-1:0]  c,
    output logic              busy,
    output logic              done
);
    localparam int W = WA + WB;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          t_q;
    logic [W-1:0]  a_sh;
    logic [WB-1:0] b_sh;
    logic [W-1:0]  acc, acc_next;
    logic          accept, last;

    // Handshake: start is only accepted in IDLE; busy is high exactly while in RUN;
    // done pulses for one cycle on the edge that loads c.
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        acc_next   = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                last = (cnt == CW'(WB - 1));
                // The top bit of a signed multiplier carries negative weight.
                if (b_sh[0]) acc_next = (last && t_q) ? acc - a_sh : acc + a_sh;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            t_q  <= 1'b0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            c    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                t_q  <= t;
                a_sh <= {{WB{t & a[WA-1]}}, a};
                b_sh <= b;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == RUN) begin
                acc  <= acc_next;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    c    <= acc_next;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_array_multiplier.sv
// Bench for seq_array_multiplier: directed vectors, handshake and reset cases,
// randomized operations on a 7x6 and an 8x8 instance.
module tb_seq_array_multiplier;
    localparam int WA  = 7;
    localparam int WB  = 6;
    localparam int W   = WA + WB;
    localparam int W8  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, t, busy, done;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [W-1:0]  c;

    logic          start8, t8, busy8, done8;
    logic [7:0]    a8, b8;
    logic [W8-1:0] c8;

    int checks = 0;
    int errors = 0;
    logic [W8-1:0] exp_q[$];

    seq_array_multiplier #(.WA(WA), .WB(WB)) u_dut (
        .clk(clk), .rst(rst), .start(start), .t(t), .a(a), .b(b),
        .c(c), .busy(busy), .done(done)
    );

    seq_array_multiplier #(.WA(8), .WB(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .t(t8), .a(a8), .b(b8),
        .c(c8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: interpret operands as integers and multiply.
    function automatic longint ref_mul(input bit tt, input longint av, input longint bv,
                                       input int wa, input int wb);
        longint x, y;
        x = av;
        y = bv;
        if (tt && x[wa-1]) x = x - (longint'(1) << wa);
        if (tt && y[wb-1]) y = y - (longint'(1) << wb);
        return x * y;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < WB + 4) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completion edge.
    task automatic run_op(input bit tt, input logic [WA-1:0] aa, input logic [WB-1:0] bb,
                          input logic [W-1:0] exp, input string tag);
        int n;
        start = 1'b1; t = tt; a = aa; b = bb;
        exp_q.push_back(W8'(exp));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = WA'($urandom); b = WB'($urandom); t = 1'($urandom);
        check({tag, "_busy"}, busy, 1);
        wait_done(n);
        check({tag, "_lat"}, n, WB);
        check({tag, "_c"}, c, exp_q.pop_front());
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_op8(input bit tt, input logic [7:0] aa, input logic [7:0] bb,
                           input logic [W8-1:0] exp, input string tag);
        int n;
        start8 = 1'b1; t8 = tt; a8 = aa; b8 = bb;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (!done8 && n < 12) begin
            check({tag, "_busy"}, busy8, 1);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_c"}, c8, exp);
    endtask

    initial begin
        int n;
        logic [W-1:0] held;
        bit tt;
        logic [WA-1:0] ra;
        logic [WB-1:0] rb;
        logic [7:0] ra8, rb8;

        rst = 1'b1; start = 1'b0; t = 1'b0; a = '0; b = '0;
        start8 = 1'b0; t8 = 1'b0; a8 = '0; b8 = '0;
        #2;
        check("rst_c", c, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors
        run_op(1'b1, 7'b1111101, 6'b000011, 13'h1FF7, "s_m3x3");
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        run_op(1'b0, 7'b1111110, 6'b111101, 13'h1E06, "u_126x61");
        run_op(1'b1, 7'b0000001, 6'b111111, 13'h1FFF, "b2b_1xm1");
        run_op(1'b1, 7'b0000010, 6'b111110, 13'h1FFC, "s_2xm2");
        run_op(1'b0, 7'b0000000, 6'b111111, 13'h0000, "u_0");
        run_op(1'b1, 7'b1000000, 6'b100000, 13'h0800, "s_minxmin");
        run_op(1'b0, 7'h7F, 6'h3F, 13'h1F41, "u_max");

        // start during RUN with changed operands is ignored
        start = 1'b1; t = 1'b1; a = 7'h7D; b = 6'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; t = 1'b0; a = 7'h33; b = 6'h2A;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ign_lat", n, WB - 3);
        check("ign_c", c, 13'h1FF1);
        held = c;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_c", c, held);
            check("hold_done", done, 0);
        end

        // Asynchronous reset mid-run
        start = 1'b1; t = 1'b0; a = 7'd2; b = 6'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_c", c, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < WB + 3; i++) begin
            @(posedge clk);
            #1;
            if (done || c != 0) n++;
        end
        check("arst_nodone", n, 0);
        run_op(1'b1, 7'd2, 6'd2, 13'h0004, "post_rst");

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            tt = 1'($urandom_range(0, 1));
            ra = (i % 10 == 0) ? '0 : WA'($urandom);
            rb = WB'($urandom);
            run_op(tt, ra, rb, W'(ref_mul(tt, longint'(ra), longint'(rb), WA, WB)), "rnd");
        end

        // 8x8 instance
        run_op8(1'b1, 8'h80, 8'h80, 16'h4000, "w8_minxmin");
        run_op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_max");
        for (int i = 0; i < 10; i++) begin
            tt = 1'($urandom_range(0, 1));
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            run_op8(tt, ra8, rb8, W8'(ref_mul(tt, longint'(ra8), longint'(rb8), 8, 8)), "w8_rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
